uart_rx_cfg: RTL
================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver for the FPGA host link. It is the successor to the fixed 8N1 receiver.
- Configurable data width, parity and stop bits.
- 3-sample majority vote at mid-bit for noise rejection.
- Frame and parity error reporting, plus break detection.
- Output holding register with a valid/ready handshake and overrun detection.
- Feeds the command/key deframer upstream of the AES/RSA cores.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, which must be >= 8 (elaboration error otherwise)
DATA_BITS, 8, payload bits per frame, legal 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
SYNC_STAGES, 2, synchroniser flops on rx_serial, >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_serial  in  1  asynchronous UART line, idle high
rx_data  out  DATA_BITS  received payload, held while rx_valid
rx_perr  out  1  parity error for the held word; 0 when PARITY = 0
rx_ferr  out  1  framing error (any stop bit sampled 0) for the held word
rx_valid  out  1  holding register full
rx_ready  in  1  consumer accepts the word when rx_valid & rx_ready
overrun_err  out  1  1-cycle pulse: a frame completed while holding register full
break_det  out  1  1-cycle pulse: break condition detected
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n low):
  - Synchroniser flops = 1; state = IDLE.
  - rx_data = 0, rx_perr/rx_ferr/rx_valid/overrun_err/break_det/busy = 0.
  - A reset mid-frame discards the frame entirely.
- Timing: all sampling uses the synchronised line rx (SYNC_STAGES of latency).
  - MID = CLKS_PER_BIT/2.
  - Within each bit period the counter runs 0..CLKS_PER_BIT-1.
  - Samples are taken at counts MID-1, MID and MID+1; the bit value is the majority of the three, evaluated at MID+1.
- States:
  - IDLE: counter cleared. rx==0 -> START (that cycle is count 0).
  - START: majority 1 -> IDLE (false start, no outputs). Majority 0 -> DATA at period end.
  - DATA: bit i is stored at position i; after DATA_BITS bits -> PARITY if PARITY != 0, else STOP.
  - PARITY: sampled bit is checked. Odd: XOR(data, p) must be 1. Even: it must be 0. Mismatch sets a perr flag.
  - STOP: STOP_BITS periods. Any stop majority 0 sets an ferr flag.
    - Frame ends at the MID+1 evaluation of the last stop bit; no full stop period is waited.
    - Stop bit good -> IDLE.
    - Stop bit bad -> WAIT_HIGH.
  - WAIT_HIGH: stay until rx==1, then IDLE. This stops a low line being re-read as a start bit.
- Break:
  - Condition: all data bits 0, parity bit 0 (if present) and the last stop bit 0.
  - Response: break_det pulses for 1 cycle, the cycle after evaluation. No word is delivered, no overrun is flagged, and the FSM enters WAIT_HIGH.
  - Only one break_det pulse per low period, however long the line stays low.
- Delivery (non-break frame end):
  - Holding register empty (or rx_valid & rx_ready in the same cycle): next cycle rx_data/rx_perr/rx_ferr are loaded and rx_valid = 1. Latency is 1 clk after the last stop evaluation.
  - Holding register full and not being accepted: the new word is dropped, the old word and its flags are kept, and overrun_err pulses for 1 cycle.
- Handshake:
  - rx_valid stays high until the cycle after rx_valid & rx_ready.
  - rx_data and the flags are stable while rx_valid is high.
  - Simultaneous accept and new frame end: the new word is loaded, rx_valid stays 1, no overrun.
- The receiver never stalls the line. Reception continues regardless of rx_ready.

Test Plan:
Common bench settings: CLK_FREQ = 1_000_000, BAUD_RATE = 100_000 (CLKS_PER_BIT = 10), rx_ready = 1 unless stated.
1. 8N1, send 0xA5 -> rx_valid for 1 cycle with rx_data = 0xA5, rx_perr = 0, rx_ferr = 0; busy falls in the same cycle rx_valid rises.
2. DATA_BITS=7, PARITY=2, STOP_BITS=2:
   - 0x03 with parity 0 -> rx_data = 0x03, rx_perr = 0.
   - 0x03 with parity 1 -> rx_perr = 1.
   - 0x03 with second stop bit 0 -> rx_ferr = 1, then the FSM waits for high before accepting the next frame.
3. Noise:
   - rx low for 3 clks then high -> no rx_valid, busy returns to 0 within 6 clks.
   - Send 0x00 with a 1-clk high glitch at count MID of bit 3 -> rx_data = 0x00.
4. Overrun: rx_ready = 0, send 0x11 then 0x22 -> rx_data stays 0x11 and rx_valid stays 1; overrun_err pulses exactly once at the 0x22 frame end. Raise rx_ready for 1 cycle -> rx_valid = 0 next cycle.
5. Break: hold rx low for 25 bit periods, then high -> exactly one break_det pulse, no rx_valid. Next 0x5A frame is received correctly.
6. Reset: assert rst_n low during data bit 4 of 0xFF -> all outputs 0 immediately, no rx_valid after release. Next 0x3C frame is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: majority-voted mid-bit sampling, parity/frame/break
// detection, and a single-word holding register with valid/ready and overrun flag.
module uart_rx_cfg #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int MID          = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int BW           = $clog2(DATA_BITS);

  generate
    if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || SYNC_STAGES < 2) begin : g_bad_cfg
      $error("uart_rx_cfg: illegal parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t                 state_r, state_n;
  logic [SYNC_STAGES-1:0] sync_r;
  logic [CW-1:0]          cnt_r;
  logic [BW-1:0]          bit_r;
  logic                   stop_r;
  logic [1:0]             samp_r;
  logic [DATA_BITS-1:0]   data_r;
  logic                   perr_r, ferr_r, pbit_r;
  logic                   rx_s, maj_s, frame_end_s, brk_s;
  logic                   mid_lo_s, mid_s, eval_s, last_s;

  // Returns 1 when the received parity bit disagrees with the configured sense.
  function automatic logic par_err(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    case (PARITY)
      1:       return ~x;
      2:       return x;
      default: return 1'b0;
    endcase
  endfunction

  assign rx_s     = sync_r[SYNC_STAGES-1];
  assign mid_lo_s = (cnt_r == CW'(MID - 1));
  assign mid_s    = (cnt_r == CW'(MID));
  assign eval_s   = (cnt_r == CW'(MID + 1));
  assign last_s   = (cnt_r == CW'(CLKS_PER_BIT - 1));
  assign maj_s    = (samp_r[0] & samp_r[1]) | (samp_r[0] & rx_s) | (samp_r[1] & rx_s);

  // Line synchroniser; resets to the idle-high level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_r <= '1;
    else        sync_r <= {sync_r[SYNC_STAGES-2:0], rx_serial};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_n;
  end

  // Next-state logic and frame-end / break strobes.
  always_comb begin
    state_n     = state_r;
    frame_end_s = 1'b0;
    brk_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!rx_s) state_n = S_START;
        else       state_n = S_IDLE;
      end
      S_START: begin
        if (eval_s && maj_s) state_n = S_IDLE;
        else if (last_s)     state_n = S_DATA;
        else                 state_n = S_START;
      end
      S_DATA: begin
        if (last_s && bit_r == BW'(DATA_BITS - 1)) state_n = (PARITY != 0) ? S_PARITY : S_STOP;
        else                                       state_n = S_DATA;
      end
      S_PARITY: begin
        if (last_s) state_n = S_STOP;
        else        state_n = S_PARITY;
      end
      S_STOP: begin
        if (eval_s && stop_r == 1'(STOP_BITS - 1)) begin
          frame_end_s = 1'b1;
          brk_s       = (data_r == '0) && ((PARITY == 0) || !pbit_r) && !maj_s;
          state_n     = (brk_s || ferr_r || !maj_s) ? S_WAIT_HIGH : S_IDLE;
        end else begin
          state_n = S_STOP;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) state_n = S_IDLE;
        else      state_n = S_WAIT_HIGH;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Bit timing, sampling and frame accumulation; the IDLE cycle that sees rx low is count 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      bit_r  <= '0;
      stop_r <= 1'b0;
      samp_r <= 2'b11;
      data_r <= '0;
      perr_r <= 1'b0;
      ferr_r <= 1'b0;
      pbit_r <= 1'b0;
    end else begin
      if (mid_lo_s) samp_r[0] <= rx_s;
      if (mid_s)    samp_r[1] <= rx_s;
      case (state_r)
        S_IDLE: begin
          cnt_r  <= rx_s ? '0 : CW'(1);
          bit_r  <= '0;
          stop_r <= 1'b0;
          perr_r <= 1'b0;
          ferr_r <= 1'b0;
          pbit_r <= 1'b0;
        end
        S_START, S_DATA, S_PARITY, S_STOP: begin
          cnt_r <= last_s ? '0 : cnt_r + CW'(1);
          if (state_r == S_DATA && eval_s)   data_r[bit_r] <= maj_s;
          if (state_r == S_DATA && last_s)   bit_r <= bit_r + BW'(1);
          if (state_r == S_PARITY && eval_s) begin
            perr_r <= par_err(data_r, maj_s);
            pbit_r <= maj_s;
          end
          if (state_r == S_STOP && eval_s && !maj_s) ferr_r <= 1'b1;
          if (state_r == S_STOP && last_s)           stop_r <= 1'b1;
        end
        default: cnt_r <= '0;
      endcase
    end
  end

  // Holding register, handshake and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_perr     <= 1'b0;
      rx_ferr     <= 1'b0;
      rx_valid    <= 1'b0;
      overrun_err <= 1'b0;
      break_det   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      busy        <= (state_n != S_IDLE);
      break_det   <= brk_s;
      overrun_err <= 1'b0;
      if (frame_end_s && !brk_s) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= data_r;
          rx_perr  <= perr_r;
          rx_ferr  <= ferr_r | !maj_s;
          rx_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
